uart_tx_fifo: RTL and testbench

- Byte FIFO and launch sequencer that sits directly upstream of uart_tx.
- Producers (command responder, debug dump logic) push bytes with a single-cycle write strobe.
- The block drains the FIFO into uart_tx one frame at a time. It drives uart_tx's go/tx_byte pair and watches its busy output.
- Producers no longer need to track the 3840-clock frame time at 38400 baud / 14.7456 MHz.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer feeding uart_tx.
// Producers push bytes with single-cycle strobes. The sequencer hands one byte
// at a time to uart_tx and waits for the frame to finish before the next launch.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no frame owned; launch when data queued and uart_tx not busy
// WAIT_BUSY   | go pulse issued; waiting for uart_tx to raise busy (bounded)
// WAIT_DONE   | frame in flight; waiting for busy to fall
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int AW           = 4,
   parameter int BUSY_TIMEOUT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr,
   input  logic          tx_busy,
   output logic          tx_go,
   output logic [7:0]    tx_byte,
   output logic          idle
);

   localparam int TW    = $clog2(BUSY_TIMEOUT + 1);
   localparam int CNT_W = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [TW-1:0]     timer_inc;
   logic              tx_go_q, tx_go_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              idle_q, idle_d;

   logic              wr_accept;
   logic              wr_drop;
   logic              pop;

   // Full is the registered flag, so a pop on the same edge never rescues a write.
   assign wr_accept = wr_en & ~full_q;
   assign wr_drop   = wr_en & full_q;
   assign pop       = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;
   assign timer_inc = timer_q + TW'(1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a missed busy pulse abandons the byte and returns to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (pop) state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (timer_inc == TW'(BUSY_TIMEOUT)) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values: launch pulse, byte latch, pointers, occupancy.
   always_comb begin
      tx_go_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      timer_d   = timer_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (pop) begin
         tx_go_d   = 1'b1;
         tx_byte_d = mem_q[rd_ptr_q];
         timer_d   = '0;
         rd_ptr_d  = rd_ptr_q + AW'(1);
      end else if (state_q == S_WAIT_BUSY && !tx_busy) begin
         timer_d = timer_inc;
      end

      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);

      if (wr_accept && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!wr_accept && pop) begin
         count_d = count_q - CNT_W'(1);
      end

      full_d = (count_d == CNT_W'(DEPTH));
      ovf_d  = wr_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
      idle_d = (count_d == '0) && (state_d == S_IDLE) && !tx_busy;
   end

   // Output and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
         timer_q   <= '0;
         tx_go_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         idle_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         timer_q   <= timer_d;
         tx_go_q   <= tx_go_d;
         tx_byte_q <= tx_byte_d;
         idle_q    <= idle_d;
      end
   end

   // Storage array; contents are don't-care after reset so it has no reset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
   end

   assign full     = full_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign tx_go    = tx_go_q;
   assign tx_byte  = tx_byte_q;
   assign idle     = idle_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a uart_tx stub plus a queue-based reference model.
module tb_uart_tx_fifo;

   localparam int DEPTH        = 16;
   localparam int AW           = 4;
   localparam int BUSY_TIMEOUT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    wr_data;
   logic          wr_en;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic          ovf_clr;
   logic          tx_busy;
   logic          tx_go;
   logic [7:0]    tx_byte;
   logic          idle;

   int total = 0;
   int bad   = 0;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr),
      .tx_busy  (tx_busy),
      .tx_go    (tx_go),
      .tx_byte  (tx_byte),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // uart_tx stub: samples go, raises busy for frame_len cycles, has no reset.
   logic stub_en   = 1'b1;
   logic hold_busy = 1'b0;
   logic stub_busy = 1'b0;
   int   stub_cnt  = 0;
   int   frame_len = 20;

   always @(posedge clk) begin
      if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) stub_busy <= 1'b0;
      end else if (stub_en && tx_go) begin
         stub_busy <= 1'b1;
         stub_cnt  <= frame_len;
      end
   end

   assign tx_busy = stub_busy | hold_busy;

   // Inputs as seen by the DUT at each rising edge.
   logic       e_wr, e_clr, e_busy;
   logic [7:0] e_data;
   always @(posedge clk) begin
      e_wr   = wr_en;
      e_data = wr_data;
      e_clr  = ovf_clr;
      e_busy = tx_busy;
   end

   // Reference model: FIFO as a queue, updated once per edge.
   logic [7:0] q[$];
   logic       m_ovf  = 1'b0;
   logic [7:0] m_last = 8'h00;
   logic       go_prev = 1'b0;
   int         go_cnt  = 0;
   int         simul_cnt = 0;

   always @(negedge clk) begin : mon
      logic was_full;
      if (rst) begin
         q.delete();
         m_ovf   = 1'b0;
         m_last  = 8'h00;
         go_prev = 1'b0;
      end else begin
         was_full = (q.size() == DEPTH);
         if (tx_go) begin
            chk("go_has_data", 32'(q.size() != 0), 1);
            chk("go_busy_low", 32'(e_busy), 0);
            chk("go_one_cycle", 32'(go_prev), 0);
            if (q.size() != 0) m_last = q.pop_front();
            chk("tx_byte", 32'(tx_byte), 32'(m_last));
            go_cnt++;
            if (e_wr && !was_full) simul_cnt++;
         end else begin
            chk("tx_byte_hold", 32'(tx_byte), 32'(m_last));
         end
         if (e_wr && !was_full) q.push_back(e_data);
         if (e_wr && was_full)  m_ovf = 1'b1;
         else if (e_clr)        m_ovf = 1'b0;
         chk("count", 32'(count), 32'(q.size()));
         chk("full", 32'(full), 32'(q.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         go_prev = tx_go;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max, input string tag);
      int n = 0;
      while ((q.size() != 0 || idle !== 1'b1) && n < max) begin
         step();
         n++;
      end
      chk(tag, 32'(n < max), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_go", 32'(tx_go), 0);
      chk("rst_byte", 32'(tx_byte), 0);
      rst = 1'b0;
      step();

      // single byte: write at edge N, go between N+1 and N+2
      wr_en = 1'b1; wr_data = 8'h41;
      step();
      wr_en = 1'b0;
      chk("lat_n1_go", 32'(tx_go), 0);
      chk("lat_n1_count", 32'(count), 1);
      step();
      chk("lat_n2_go", 32'(tx_go), 1);
      chk("lat_n2_byte", 32'(tx_byte), 8'h41);
      step();
      chk("single_go_low", 32'(tx_go), 0);
      chk("single_busy_idle", 32'(idle), 0);
      wait_drain(100, "single_drain");
      chk("single_idle", 32'(idle), 1);
      chk("single_byte_stable", 32'(tx_byte), 8'h41);

      // write on the same edge as a pop
      hold_busy = 1'b1;
      wr_en = 1'b1; wr_data = 8'hA1;
      step();
      wr_en = 1'b0;
      step();
      chk("held_no_go", 32'(tx_go), 0);
      hold_busy = 1'b0;
      wr_en = 1'b1; wr_data = 8'hA2;
      step();
      wr_en = 1'b0;
      chk("simul_go", 32'(tx_go), 1);
      chk("simul_count", 32'(count), 1);
      chk("simul_byte", 32'(tx_byte), 8'hA1);
      wait_drain(100, "simul_drain");

      // burst to full, then overflow behaviour
      hold_busy = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      chk("burst_full", 32'(full), 1);
      chk("burst_count", 32'(count), 16);
      wr_en = 1'b1; wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 16);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
      wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
      step();
      wr_en = 1'b0; ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr2", 32'(overflow), 0);
      base = go_cnt;
      hold_busy = 1'b0;
      wait_drain(16 * (frame_len + 8) + 50, "burst_drain");
      chk("burst_frames", 32'(go_cnt - base), 16);

      // random writes interleaved with transmission, wrapping the pointers
      frame_len = 4;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 14)) step();
         wr_en = 1'b1; wr_data = 8'($urandom);
         step();
         wr_en = 1'b0;
      end
      wait_drain(600, "wrap_drain");
      chk("simul_seen", 32'(simul_cnt > 0), 1);

      // busy never rises: one pulse, timeout back to IDLE
      stub_en = 1'b0;
      base = go_cnt;
      wr_en = 1'b1; wr_data = 8'h3C;
      step();
      wr_en = 1'b0;
      step();
      chk("to_go", 32'(tx_go), 1);
      chk("to_byte", 32'(tx_byte), 8'h3C);
      step();
      chk("to_waiting", 32'(idle), 0);
      n = 0;
      while (idle !== 1'b1 && n < BUSY_TIMEOUT + 3) begin
         step();
         n++;
      end
      chk("to_return", 32'(idle), 1);
      chk("to_count", 32'(count), 0);
      repeat (10) step();
      chk("to_single_go", 32'(go_cnt - base), 1);
      wr_en = 1'b1; wr_data = 8'h5A;
      step();
      wr_en = 1'b0;
      step();
      chk("to_relaunch", 32'(tx_go), 1);
      repeat (10) step();
      stub_en = 1'b1;

      // reset during frame 2 of 5
      frame_len = 30;
      base = go_cnt;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         step();
      end
      wr_en = 1'b0;
      n = 0;
      while (go_cnt - base < 2 && n < 200) begin
         step();
         n++;
      end
      chk("rst_frame2_seen", 32'(go_cnt - base), 2);
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_go", 32'(tx_go), 0);
      chk("rst_mid_full", 32'(full), 0);
      step();
      rst = 1'b0;
      wr_en = 1'b1; wr_data = 8'h55;
      step();
      wr_en = 1'b0;
      chk("rst_55_count", 32'(count), 1);
      chk("rst_55_wait", 32'(tx_go), 0);
      n = 0;
      while (tx_go !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("rst_55_go", 32'(tx_go), 1);
      chk("rst_55_byte", 32'(tx_byte), 8'h55);
      wait_drain(100, "rst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
